// File: rtl/yazmac_oku_asamasi.sv
// Issue/operand-read stage: holds one decoded uop until its sources are valid,
// allocates a destination tag, and hands uop+operands+tag to execute.
`ifndef VERI_BIT
`define VERI_BIT 32
`endif
`ifndef YAZMAC_BIT
`define YAZMAC_BIT 5
`endif
`ifndef UOP_TAG_BIT
`define UOP_TAG_BIT 4
`endif

module yazmac_oku_asamasi #(
    parameter int UOP_BIT = 64
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [UOP_BIT-1:0]      uop_i,
    input  logic [`YAZMAC_BIT-1:0]  rs1_i,
    input  logic [`YAZMAC_BIT-1:0]  rs2_i,
    input  logic [`YAZMAC_BIT-1:0]  rd_i,
    input  logic                    rs1_kullan_i,
    input  logic                    rs2_kullan_i,
    input  logic                    rd_yaz_i,
    input  logic                    uop_gecerli_i,
    output logic                    uop_hazir_o,
    output logic [`YAZMAC_BIT-1:0]  oku_adres1_o,
    output logic [`YAZMAC_BIT-1:0]  oku_adres2_o,
    input  logic [`VERI_BIT-1:0]    oku_veri1_i,
    input  logic [`VERI_BIT-1:0]    oku_veri2_i,
    input  logic                    oku_veri1_gecerli_i,
    input  logic                    oku_veri2_gecerli_i,
    output logic [`UOP_TAG_BIT-1:0] etiket_o,
    output logic [`YAZMAC_BIT-1:0]  etiket_adres_o,
    output logic                    etiket_gecerli_o,
    input  logic [`YAZMAC_BIT-1:0]  gy_adres_i,
    input  logic                    gy_gecerli_i,
    output logic [UOP_BIT-1:0]      cikis_uop_o,
    output logic [`VERI_BIT-1:0]    cikis_rs1_o,
    output logic [`VERI_BIT-1:0]    cikis_rs2_o,
    output logic [`UOP_TAG_BIT-1:0] cikis_etiket_o,
    output logic [`YAZMAC_BIT-1:0]  cikis_rd_o,
    output logic                    cikis_gecerli_o,
    input  logic                    cikis_hazir_i
);
    typedef enum logic {BOS, BEKLE} durum_t;

    typedef struct packed {
        logic [UOP_BIT-1:0]     uop;
        logic [`YAZMAC_BIT-1:0] rs1;
        logic [`YAZMAC_BIT-1:0] rs2;
        logic [`YAZMAC_BIT-1:0] rd;
        logic                   rs1_kullan;
        logic                   rs2_kullan;
        logic                   rd_yaz;
    } tutucu_t;

    durum_t                  durum_q, durum_d;
    tutucu_t                 tutucu_q;
    logic [`UOP_TAG_BIT-1:0] sayac_q;
    logic                    hazir1, hazir2, cakisma, gonder, kabul, etiket_yaz;

    assign hazir1 = !tutucu_q.rs1_kullan || oku_veri1_gecerli_i;
    assign hazir2 = !tutucu_q.rs2_kullan || oku_veri2_gecerli_i;

    // Holding back an issue while rd is being written back keeps the register
    // file from seeing a tag install and a writeback to one index in one cycle.
    assign cakisma = tutucu_q.rd_yaz && (tutucu_q.rd != '0) && gy_gecerli_i &&
                     (gy_adres_i == tutucu_q.rd);

    assign gonder      = (durum_q == BEKLE) && hazir1 && hazir2 && !cakisma &&
                         (!cikis_gecerli_o || cikis_hazir_i);
    assign uop_hazir_o = (durum_q == BOS) || gonder;
    assign kabul       = uop_gecerli_i && uop_hazir_o;
    assign etiket_yaz  = gonder && tutucu_q.rd_yaz && (tutucu_q.rd != '0);

    assign oku_adres1_o     = (durum_q == BEKLE) ? tutucu_q.rs1 : rs1_i;
    assign oku_adres2_o     = (durum_q == BEKLE) ? tutucu_q.rs2 : rs2_i;
    assign etiket_o         = sayac_q;
    assign etiket_adres_o   = tutucu_q.rd;
    assign etiket_gecerli_o = etiket_yaz;

    always_comb begin
        durum_d = durum_q;
        if (kabul)
            durum_d = BEKLE;
        else if (gonder)
            durum_d = BOS;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q  <= BOS;
            tutucu_q <= '0;
        end else begin
            durum_q <= durum_d;
            if (kabul)
                tutucu_q <= '{uop: uop_i, rs1: rs1_i, rs2: rs2_i, rd: rd_i,
                              rs1_kullan: rs1_kullan_i, rs2_kullan: rs2_kullan_i,
                              rd_yaz: rd_yaz_i};
        end
    end

    // Tag 0 means "no producer", so the counter skips it on wrap.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            sayac_q <= `UOP_TAG_BIT'(1);
        else if (etiket_yaz)
            sayac_q <= (sayac_q == '1) ? `UOP_TAG_BIT'(1) : sayac_q + `UOP_TAG_BIT'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cikis_gecerli_o <= 1'b0;
            cikis_uop_o     <= '0;
            cikis_rs1_o     <= '0;
            cikis_rs2_o     <= '0;
            cikis_etiket_o  <= '0;
            cikis_rd_o      <= '0;
        end else if (gonder) begin
            cikis_gecerli_o <= 1'b1;
            cikis_uop_o     <= tutucu_q.uop;
            cikis_rs1_o     <= oku_veri1_i;
            cikis_rs2_o     <= oku_veri2_i;
            cikis_etiket_o  <= etiket_yaz ? sayac_q : '0;
            cikis_rd_o      <= tutucu_q.rd;
        end else if (cikis_hazir_i) begin
            cikis_gecerli_o <= 1'b0;
        end
    end
endmodule
